// File: rtl/layer_pkg.sv
// Shared definitions for the fully connected layer sequencer: FSM states,
// activation ceiling and address-width helpers.
package layer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        BIAS  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int ACT_MAX = 127;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-entry memory still needs a 1-bit address port.
    function automatic int addr_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/layer_seq_mac_acc.sv
// Signed accumulator datapath: clear, multiply-accumulate of 8x8 products,
// and a final bias add, all into one ACC_W-bit register.
module mac_acc
    import layer_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bias_en,
    input  logic [7:0]       x,
    input  logic [7:0]       w,
    input  logic [7:0]       b,
    output logic [ACC_W-1:0] acc
);

    logic signed [15:0] prod_s;
    logic [ACC_W-1:0]   prod_ext_s;
    logic [ACC_W-1:0]   bias_ext_s;

    assign prod_s     = $signed(x) * $signed(w);
    assign prod_ext_s = {{(ACC_W-16){prod_s[15]}}, prod_s};
    assign bias_ext_s = {{(ACC_W-8){b[7]}}, b};

    // Accumulator register; clear has priority over accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext_s;
        end else if (bias_en) begin
            acc <= acc + bias_ext_s;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/layer_seq.sv
// Fully connected layer sequencer: walks weight/input ROMs per neuron,
// accumulates, adds bias, applies ReLU/shift/saturation and writes the result.
module layer_seq
    import layer_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [addr_w(N_IN)-1:0]          x_addr,
    input  logic [7:0]                       x_data,
    output logic [addr_w(N_IN*N_OUT)-1:0]    w_addr,
    input  logic [7:0]                       w_data,
    output logic [addr_w(N_OUT)-1:0]         b_addr,
    input  logic [7:0]                       b_data,
    output logic                             y_wr,
    output logic [addr_w(N_OUT)-1:0]         y_addr,
    output logic [7:0]                       y_data
);

    localparam int XW = addr_w(N_IN);
    localparam int WW = addr_w(N_IN*N_OUT);
    localparam int JW = addr_w(N_OUT);
    localparam int IW = clog2(N_IN + 1);

    state_t         state_r, state_nx_s;
    logic [IW-1:0]  i_r, i_nx_s;
    logic [JW-1:0]  j_r, j_nx_s;
    logic [XW-1:0]  x_addr_r, x_addr_nx_s;
    logic [WW-1:0]  w_addr_r, w_addr_nx_s;
    logic [JW-1:0]  b_addr_r, b_addr_nx_s;
    logic [JW-1:0]  y_addr_r;
    logic [7:0]     y_data_r;
    logic           y_wr_r, busy_r, done_r;

    logic             acc_clr_s, acc_en_s, bias_en_s;
    logic [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] biased_s, shifted_s;
    logic [7:0]       act_s;

    mac_acc #(.ACC_W(ACC_W)) u_mac_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr_s),
        .en      (acc_en_s),
        .bias_en (bias_en_s),
        .x       (x_data),
        .w       (w_data),
        .b       (b_data),
        .acc     (acc_s)
    );

    // Next-state, counter and address sequencing.
    always_comb begin
        state_nx_s  = state_r;
        i_nx_s      = i_r;
        j_nx_s      = j_r;
        x_addr_nx_s = x_addr_r;
        w_addr_nx_s = w_addr_r;
        b_addr_nx_s = b_addr_r;
        acc_clr_s   = 1'b0;
        acc_en_s    = 1'b0;
        bias_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s  = CLEAR;
                    j_nx_s      = '0;
                    b_addr_nx_s = '0;
                end else begin
                    state_nx_s  = IDLE;
                end
            end
            CLEAR: begin
                acc_clr_s   = 1'b1;
                i_nx_s      = '0;
                x_addr_nx_s = '0;
                w_addr_nx_s = WW'(int'(j_r) * N_IN);
                state_nx_s  = MAC;
            end
            MAC: begin
                // ROM data lags the address by one cycle, so accumulation
                // starts at k=1 and the final cycle only drains.
                acc_en_s = (i_r != IW'(0));
                if (i_r == IW'(N_IN)) begin
                    state_nx_s = BIAS;
                end else begin
                    i_nx_s = i_r + IW'(1);
                    if (i_r < IW'(N_IN - 1)) begin
                        x_addr_nx_s = x_addr_r + XW'(1);
                        w_addr_nx_s = w_addr_r + WW'(1);
                    end else begin
                        x_addr_nx_s = x_addr_r;
                        w_addr_nx_s = w_addr_r;
                    end
                end
            end
            BIAS: begin
                bias_en_s  = 1'b1;
                state_nx_s = WRITE;
            end
            WRITE: begin
                if (j_r == JW'(N_OUT - 1)) begin
                    state_nx_s = DONE;
                end else begin
                    j_nx_s      = j_r + JW'(1);
                    b_addr_nx_s = j_r + JW'(1);
                    state_nx_s  = CLEAR;
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Output formatting; evaluated during BIAS so the write data can be registered.
    always_comb begin
        biased_s  = acc_s + {{(ACC_W-8){b_data[7]}}, b_data};
        shifted_s = biased_s >>> SHIFT;
        act_s     = 8'd0;
        if (biased_s[ACC_W-1]) begin
            act_s = 8'd0;
        end else if (shifted_s > ACC_W'(ACT_MAX)) begin
            act_s = 8'(ACT_MAX);
        end else begin
            act_s = shifted_s[7:0];
        end
    end

    // State, counters and registered outputs; strobes decode the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            i_r      <= '0;
            j_r      <= '0;
            x_addr_r <= '0;
            w_addr_r <= '0;
            b_addr_r <= '0;
            y_addr_r <= '0;
            y_data_r <= 8'd0;
            y_wr_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            i_r      <= i_nx_s;
            j_r      <= j_nx_s;
            x_addr_r <= x_addr_nx_s;
            w_addr_r <= w_addr_nx_s;
            b_addr_r <= b_addr_nx_s;
            y_wr_r   <= (state_nx_s == WRITE);
            busy_r   <= (state_nx_s != IDLE);
            done_r   <= (state_nx_s == DONE);
            if (state_nx_s == WRITE) begin
                y_data_r <= act_s;
                y_addr_r <= j_r;
            end else begin
                y_data_r <= y_data_r;
                y_addr_r <= y_addr_r;
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign x_addr = x_addr_r;
    assign w_addr = w_addr_r;
    assign b_addr = b_addr_r;
    assign y_wr   = y_wr_r;
    assign y_addr = y_addr_r;
    assign y_data = y_data_r;

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: table of ROM contents with hand-computed
// activations, plus sequences for start-while-busy, mid-run reset and back-to-back runs.
module tb_layer_seq;

    logic       clk = 1'b0;
    logic       rst, start;
    logic       busy, done, y_wr;
    logic [1:0] x_addr;
    logic [2:0] w_addr;
    logic [0:0] b_addr, y_addr;
    logic [7:0] x_data, w_data, b_data, y_data;

    logic       busy9, done9, y_wr9;
    logic [1:0] x_addr9;
    logic [2:0] w_addr9;
    logic [0:0] b_addr9, y_addr9;
    logic [7:0] y_data9;

    layer_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
        .b_addr(b_addr), .b_data(b_data), .y_wr(y_wr), .y_addr(y_addr), .y_data(y_data)
    );

    layer_seq #(.SHIFT(9)) dut9 (
        .clk(clk), .rst(rst), .start(start), .busy(busy9), .done(done9),
        .x_addr(x_addr9), .x_data(x_data), .w_addr(w_addr9), .w_data(w_data),
        .b_addr(b_addr9), .b_data(b_data), .y_wr(y_wr9), .y_addr(y_addr9), .y_data(y_data9)
    );

    always #5 clk = ~clk;

    logic [7:0] x_rom [4];
    logic [7:0] w_rom [8];
    logic [7:0] b_rom [2];

    always @(posedge clk) begin
        x_data <= x_rom[x_addr];
        w_data <= w_rom[w_addr];
        b_data <= b_rom[b_addr];
    end

    typedef struct packed {
        logic [3:0][7:0] x;
        logic [7:0][7:0] w;
        logic [1:0][7:0] b;
        logic [7:0]      y0;
        logic [7:0]      y1;
        logic [7:0]      y0s9;
        logic [7:0]      y1s9;
    } vec_t;

    vec_t vecs [4];

    int checks = 0;
    int errors = 0;

    int   wr_cnt, wr9_cnt, done_cnt, done_cyc;
    int   wr_cyc [4];
    int   wr_adr [4];
    int   wr_dat [4];
    int   wr_dat9 [4];
    logic       busy_log [32];
    logic [1:0] xa_log [32];
    logic [2:0] wa_log [32];
    logic [0:0] ba_log [32];

    function automatic logic [7:0] b8(input int v);
        return 8'(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input int v);
        for (int k = 0; k < 4; k++) x_rom[k] = vecs[v].x[k];
        for (int k = 0; k < 8; k++) w_rom[k] = vecs[v].w[k];
        for (int k = 0; k < 2; k++) b_rom[k] = vecs[v].b[k];
    endtask

    // Start a layer, optionally pulse start again or reset in a given cycle,
    // and log outputs sampled on the falling edge of cycles 1..ncyc.
    task automatic run_layer(input int pulse_c, input int rst_c, input int ncyc);
        wr_cnt = 0; wr9_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            wr_cyc[k] = -1; wr_adr[k] = -1; wr_dat[k] = -1; wr_dat9[k] = -1;
        end
        for (int k = 0; k < 32; k++) busy_log[k] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = (c == pulse_c);
            busy_log[c] = busy;
            xa_log[c]   = x_addr;
            wa_log[c]   = w_addr;
            ba_log[c]   = b_addr;
            if (y_wr) begin
                if (wr_cnt < 4) begin
                    wr_cyc[wr_cnt]  = c;
                    wr_adr[wr_cnt]  = int'(y_addr);
                    wr_dat[wr_cnt]  = int'(y_data);
                    wr_dat9[wr_cnt] = int'(y_data9);
                end
                wr_cnt = wr_cnt + 1;
            end
            if (y_wr9) wr9_cnt = wr9_cnt + 1;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = c;
            end
            if (c == rst_c) begin
                rst = 1'b1;
                #1;
                check("rst_mid_outputs",
                      {busy, done, y_wr, y_data, x_addr, w_addr, b_addr, y_addr}, 64'd0);
            end else if (c == rst_c + 1) begin
                rst = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string tag, input int e0, input int e1,
                             input int e0s9, input int e1s9);
        int nb;
        check({tag, "_wr_cnt"},   wr_cnt, 2);
        check({tag, "_wr9_cnt"},  wr9_cnt, 2);
        check({tag, "_wr0_cyc"},  wr_cyc[0], 8);
        check({tag, "_wr0_adr"},  wr_adr[0], 0);
        check({tag, "_y0"},       wr_dat[0], e0);
        check({tag, "_y0_s9"},    wr_dat9[0], e0s9);
        check({tag, "_wr1_cyc"},  wr_cyc[1], 16);
        check({tag, "_wr1_adr"},  wr_adr[1], 1);
        check({tag, "_y1"},       wr_dat[1], e1);
        check({tag, "_y1_s9"},    wr_dat9[1], e1s9);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, 17);
        nb = 0;
        for (int c = 1; c <= 17; c++) if (busy_log[c] !== 1'b1) nb = nb + 1;
        check({tag, "_busy_low_cycles"}, nb, 0);
        check({tag, "_y_hold"}, y_data, e1);
    endtask

    initial begin
        vecs[0].x = {b8(4), b8(3), b8(2), b8(1)};
        vecs[0].w = {b8(-4), b8(-3), b8(-2), b8(-1), b8(1), b8(1), b8(1), b8(1)};
        vecs[0].b = {b8(11), b8(11)};
        vecs[0].y0 = 8'd21;  vecs[0].y1 = 8'd0;  vecs[0].y0s9 = 8'd0;   vecs[0].y1s9 = 8'd0;

        vecs[1].x = {b8(127), b8(127), b8(127), b8(127)};
        vecs[1].w = {b8(0), b8(0), b8(0), b8(1), b8(127), b8(127), b8(127), b8(127)};
        vecs[1].b = {b8(-100), b8(0)};
        vecs[1].y0 = 8'd127; vecs[1].y1 = 8'd27; vecs[1].y0s9 = 8'd126; vecs[1].y1s9 = 8'd0;

        vecs[2].x = {b8(-128), b8(-128), b8(-128), b8(-128)};
        vecs[2].w = {b8(-1), b8(1), b8(-1), b8(1), b8(-128), b8(-128), b8(-128), b8(-128)};
        vecs[2].b = {b8(5), b8(-128)};
        vecs[2].y0 = 8'd127; vecs[2].y1 = 8'd5;  vecs[2].y0s9 = 8'd127; vecs[2].y1s9 = 8'd0;

        vecs[3].x = {b8(0), b8(7), b8(-3), b8(5)};
        vecs[3].w = {b8(3), b8(3), b8(-3), b8(3), b8(100), b8(-1), b8(4), b8(2)};
        vecs[3].b = {b8(0), b8(20)};
        vecs[3].y0 = 8'd11;  vecs[3].y1 = 8'd45; vecs[3].y0s9 = 8'd0;   vecs[3].y1s9 = 8'd0;

        rst = 1'b1;
        start = 1'b0;
        load_vec(0);
        #12;
        check("reset_state", {busy, done, y_wr, y_data, x_addr, w_addr, b_addr, y_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            run_layer(-1, -1, 17);
            check_run($sformatf("vec%0d", v), int'(vecs[v].y0), int'(vecs[v].y1),
                      int'(vecs[v].y0s9), int'(vecs[v].y1s9));
            if (v == 0) begin
                check("addr_mac_k0", {xa_log[2], wa_log[2]}, {2'd0, 3'd0});
                check("addr_mac_k1", {xa_log[3], wa_log[3]}, {2'd1, 3'd1});
                check("addr_drain_hold", {xa_log[6], wa_log[6]}, {2'd3, 3'd3});
                check("addr_n1_k0", wa_log[10], 3'd4);
                check("addr_n1_k1", wa_log[11], 3'd5);
                check("b_addr_n1", ba_log[9], 1'd1);
            end
        end

        load_vec(0);
        run_layer(5, -1, 17);
        check_run("start_busy", 21, 0, 0, 0);

        run_layer(17, -1, 18);
        check_run("start_at_done", 21, 0, 0, 0);
        check("start_at_done_idle", busy_log[18], 1'b0);

        load_vec(1);
        run_layer(-1, 10, 20);
        check("rstmid_wr_cnt", wr_cnt, 1);
        check("rstmid_wr0", wr_dat[0], 127);
        check("rstmid_done_cnt", done_cnt, 0);
        check("rstmid_busy_after", {busy_log[12], busy_log[16], busy_log[20]}, 3'b000);
        check("rstmid_y_data", y_data, 8'd0);
        load_vec(0);
        run_layer(-1, -1, 17);
        check_run("after_rst", 21, 0, 0, 0);

        load_vec(3);
        run_layer(-1, -1, 17);
        check_run("b2b_first", 11, 45, 0, 0);
        run_layer(-1, -1, 17);
        check_run("b2b_second", 11, 45, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
